// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;
  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RESP = 2'd2} state_e;

  // Illegal size or an address not aligned to the access size.
  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication/bweb, misalignment check,
// and load lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic        st_err,
  output logic [31:0] st_di,
  output logic [31:0] st_bweb,
  input  size_e       ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_do,
  output logic [31:0] ld_data
);
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic        ld_sign;

  assign st_err = misaligned(st_size, st_lo);

  // Store data replication and active-low lane mask.
  always_comb begin
    st_di   = 32'h0000_0000;
    st_bweb = 32'hFFFF_FFFF;
    case (st_size)
      SZ_B: begin
        st_di   = {LANES{st_wdata[BYTE_W-1:0]}};
        st_bweb = ~(32'h0000_00FF << {st_lo, 3'b000});
      end
      SZ_H: begin
        st_di   = {2{st_wdata[15:0]}};
        st_bweb = ~(32'h0000_FFFF << {st_lo[1], 4'b0000});
      end
      SZ_W: begin
        st_di   = st_wdata;
        st_bweb = 32'h0000_0000;
      end
      default: begin
        st_di   = 32'h0000_0000;
        st_bweb = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign byte_sh = ld_do >> {ld_lo, 3'b000};
  assign half_sh = ld_do >> {ld_lo[1], 4'b0000};

  // Load field select and extension.
  always_comb begin
    ld_sign = 1'b0;
    ld_data = 32'h0000_0000;
    case (ld_size)
      SZ_B: begin
        ld_sign = byte_sh[7] & ~ld_unsigned;
        ld_data = {{24{ld_sign}}, byte_sh[7:0]};
      end
      SZ_H: begin
        ld_sign = half_sh[15] & ~ld_unsigned;
        ld_data = {{16{ld_sign}}, half_sh[15:0]};
      end
      SZ_W: begin
        ld_sign = 1'b0;
        ld_data = ld_do;
      end
      default: begin
        ld_sign = 1'b0;
        ld_data = 32'h0000_0000;
      end
    endcase
  end
endmodule

// File: rtl/dm_lsu.sv
// Load/store unit between the CPU and the data SRAM: request FSM, SRAM
// port drive in the accept cycle, and registered single-pulse response.
module dm_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [DATA_W-1:0] sram_bweb,
  output logic [ADDR_W-3:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);
  state_e      state;
  size_e       ld_size_r;
  logic [1:0]  ld_lo_r;
  logic        ld_unsigned_r;
  logic        err_s;
  logic        accept_s;
  logic        mem_go_s;
  logic [31:0] st_di_s;
  logic [31:0] st_bweb_s;
  logic [31:0] ld_data_s;

  lsu_align u_align (
    .st_size     (size_e'(req_size)),
    .st_lo       (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .st_err      (err_s),
    .st_di       (st_di_s),
    .st_bweb     (st_bweb_s),
    .ld_size     (ld_size_r),
    .ld_lo       (ld_lo_r),
    .ld_unsigned (ld_unsigned_r),
    .ld_do       (sram_do),
    .ld_data     (ld_data_s)
  );

  assign req_ready = (state == IDLE);
  assign accept_s  = req_ready & req_valid;
  assign mem_go_s  = accept_s & ~err_s;
  assign sram_a    = req_addr[ADDR_W-1:2];

  // SRAM strobes exist only in an error-free accept cycle.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = 32'hFFFF_FFFF;
    sram_di   = 32'h0000_0000;
    if (mem_go_s) begin
      sram_ceb = 1'b0;
      sram_web = ~req_we;
      if (req_we) begin
        sram_bweb = st_bweb_s;
        sram_di   = st_di_s;
      end else begin
        sram_bweb = 32'hFFFF_FFFF;
        sram_di   = 32'h0000_0000;
      end
    end else begin
      sram_ceb  = 1'b1;
      sram_web  = 1'b1;
      sram_bweb = 32'hFFFF_FFFF;
      sram_di   = 32'h0000_0000;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= 32'h0000_0000;
      ld_size_r     <= SZ_B;
      ld_lo_r       <= 2'b00;
      ld_unsigned_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ld_size_r     <= size_e'(req_size);
            ld_lo_r       <= req_addr[1:0];
            ld_unsigned_r <= req_unsigned;
            if (err_s || req_we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err_s;
              rsp_rdata <= 32'h0000_0000;
            end else begin
              state <= RD_WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ld_data_s;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dm_lsu.sv
// Directed self-checking bench for dm_lsu with a one-cycle-latency SRAM model.
module tb_dm_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sram_ceb;
  logic        sram_web;
  logic [31:0] sram_bweb;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  logic [31:0] mem [0:16383];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  dm_lsu #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sram_ceb(sram_ceb),
    .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  // SRAM model: masked write, registered read.
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
      else sram_do <= mem[sram_a];
    end
  end

  always @(negedge clk) if (rsp_valid === 1'b1) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [15:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    #1;
  endtask

  task automatic finish_req(input string tag, input logic is_load, input logic exp_err,
                            input logic [31:0] exp_rdata);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (is_load) begin
      @(negedge clk);
      check1({tag, "_wait_valid"}, rsp_valid, 1'b0);
      check1({tag, "_wait_ready"}, req_ready, 1'b0);
    end
    @(negedge clk);
    check1({tag, "_valid"}, rsp_valid, 1'b1);
    check1({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check1({tag, "_resp_ready"}, req_ready, 1'b0);
    @(negedge clk);
    check1({tag, "_end_valid"}, rsp_valid, 1'b0);
    check1({tag, "_end_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 16'h0000; req_wdata = 32'h0000_0000;
    repeat (2) @(negedge clk);
    check1("rst_valid", rsp_valid, 1'b0);
    check1("rst_err", rsp_err, 1'b0);
    check("rst_rdata", rsp_rdata, 32'h0000_0000);
    check1("rst_ready", req_ready, 1'b1);
    check1("rst_ceb", sram_ceb, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    drive(1'b1, 2'd2, 1'b0, 16'h0020, 32'h5566_7788);
    finish_req("init_st", 1'b0, 1'b0, 32'h0000_0000);

    drive(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF);
    check1("wst_ceb", sram_ceb, 1'b0);
    check1("wst_web", sram_web, 1'b0);
    check("wst_bweb", sram_bweb, 32'h0000_0000);
    check("wst_a", {18'd0, sram_a}, 32'h0000_0004);
    check("wst_di", sram_di, 32'hDEAD_BEEF);
    finish_req("wst", 1'b0, 1'b0, 32'h0000_0000);
    drive(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0000_0000);
    check1("wld_ceb", sram_ceb, 1'b0);
    check1("wld_web", sram_web, 1'b1);
    check("wld_bweb", sram_bweb, 32'hFFFF_FFFF);
    finish_req("wld", 1'b1, 1'b0, 32'hDEAD_BEEF);

    drive(1'b1, 2'd0, 1'b0, 16'h0013, 32'h0000_0080);
    check("bst_bweb", sram_bweb, 32'h00FF_FFFF);
    check("bst_di", sram_di, 32'h8080_8080);
    finish_req("bst", 1'b0, 1'b0, 32'h0000_0000);
    drive(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0000_0000);
    finish_req("bld_s", 1'b1, 1'b0, 32'hFFFF_FF80);
    drive(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0000_0000);
    finish_req("bld_u", 1'b1, 1'b0, 32'h0000_0080);
    drive(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0000_0000);
    finish_req("bld_w", 1'b1, 1'b0, 32'h80AD_BEEF);

    drive(1'b1, 2'd1, 1'b0, 16'h0022, 32'h1234_ABCD);
    check("hst_bweb", sram_bweb, 32'h0000_FFFF);
    check("hst_di", sram_di, 32'hABCD_ABCD);
    finish_req("hst", 1'b0, 1'b0, 32'h0000_0000);
    drive(1'b0, 2'd1, 1'b0, 16'h0022, 32'h0000_0000);
    finish_req("hld_s", 1'b1, 1'b0, 32'hFFFF_ABCD);
    drive(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0000_0000);
    finish_req("hld_w", 1'b1, 1'b0, 32'hABCD_7788);
    drive(1'b0, 2'd1, 1'b1, 16'h0020, 32'h0000_0000);
    finish_req("hld_u", 1'b1, 1'b0, 32'h0000_7788);
    drive(1'b0, 2'd0, 1'b0, 16'h0021, 32'h0000_0000);
    finish_req("bld_77", 1'b1, 1'b0, 32'h0000_0077);

    drive(1'b1, 2'd2, 1'b0, 16'h0011, 32'hFFFF_FFFF);
    check1("e_wst_ceb", sram_ceb, 1'b1);
    check1("e_wst_web", sram_web, 1'b1);
    check("e_wst_bweb", sram_bweb, 32'hFFFF_FFFF);
    finish_req("e_wst", 1'b0, 1'b1, 32'h0000_0000);
    drive(1'b0, 2'd1, 1'b0, 16'h0021, 32'h0000_0000);
    check1("e_hld_ceb", sram_ceb, 1'b1);
    finish_req("e_hld", 1'b0, 1'b1, 32'h0000_0000);
    drive(1'b1, 2'd3, 1'b0, 16'h0010, 32'h0000_0000);
    check1("e_sz3_ceb", sram_ceb, 1'b1);
    finish_req("e_sz3", 1'b0, 1'b1, 32'h0000_0000);
    drive(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0000_0000);
    finish_req("e_keep", 1'b1, 1'b0, 32'h80AD_BEEF);

    p0 = pulses;
    drive(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0000_0000);
    check1("b2b_ready0", req_ready, 1'b1);
    @(posedge clk);
    #1 req_addr = 16'h0020;
    @(negedge clk);
    check1("b2b_rdwait_ready", req_ready, 1'b0);
    check1("b2b_rdwait_ceb", sram_ceb, 1'b1);
    @(negedge clk);
    check1("b2b_resp_valid", rsp_valid, 1'b1);
    check("b2b_resp_rdata", rsp_rdata, 32'h80AD_BEEF);
    check1("b2b_resp_ready", req_ready, 1'b0);
    check1("b2b_resp_ceb", sram_ceb, 1'b1);
    @(negedge clk);
    check1("b2b_idle_ready", req_ready, 1'b1);
    check1("b2b_idle_valid", rsp_valid, 1'b0);
    check1("b2b_idle_ceb", sram_ceb, 1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check1("b2b_2_wait", rsp_valid, 1'b0);
    @(negedge clk);
    check1("b2b_2_valid", rsp_valid, 1'b1);
    check("b2b_2_rdata", rsp_rdata, 32'hABCD_7788);
    @(negedge clk);
    check1("b2b_2_end", rsp_valid, 1'b0);
    check("b2b_pulses", pulses - p0, 32'd2);

    drive(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0000_0000);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    p0 = pulses;
    rst = 1'b1;
    #1;
    check1("mrst_valid", rsp_valid, 1'b0);
    check1("mrst_ready", req_ready, 1'b1);
    check("mrst_rdata", rsp_rdata, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check1("mrst_after_valid", rsp_valid, 1'b0);
    check1("mrst_after_ready", req_ready, 1'b1);
    check("mrst_pulses", pulses - p0, 32'd0);
    drive(1'b0, 2'd0, 1'b1, 16'h0023, 32'h0000_0000);
    finish_req("mrst_ld", 1'b1, 1'b0, 32'h0000_00AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
